// File: rtl/sec_tick_ctrl.sv
// sec_tick_ctrl: stopwatch front end. Two raw buttons are synchronized,
// debounced and edge-detected into press events that drive an
// IDLE/RUN/PAUSE state machine and a tick prescaler.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - synchronous active-low reset
//   btn_ss   - raw start/stop button (async, active-high)
//   btn_clr  - raw clear button (async, active-high)
//   tick     - registered one-cycle pulse every TICK_DIV RUN cycles
//   clr      - registered one-cycle pulse per clear press
//   running  - registered level, high while in RUN
module sec_tick_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEB_CYC  = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic tick,
    output logic clr,
    output logic running
);

    localparam int NB = 2;                    // bit 0 = start/stop, bit 1 = clear
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [NB-1:0]         btn_raw;
    logic [NB-1:0]         sync1_q, sync2_q;
    logic [NB-1:0]         deb_q, deb_d;
    logic [NB-1:0]         deb_prev_q;
    logic [NB-1:0][DW-1:0] dcnt_q, dcnt_d;
    logic [NB-1:0]         ev;
    logic                  ss_ev, clr_ev;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;
    logic          running_q, running_d;
    logic          wrap;

    assign btn_raw = {btn_clr, btn_ss};

    // Debounce: the counter only runs while the synced level disagrees with
    // the accepted level; the last counted cycle flips the accepted level.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEB_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Rising edges of the accepted levels only; releases are silent.
    assign ev     = deb_q & ~deb_prev_q;
    assign ss_ev  = ev[0];
    assign clr_ev = ev[1];

    assign wrap = (pcnt_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tick_d  = 1'b0;
        clr_d   = clr_ev;

        case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                if (ss_ev) state_d = S_RUN;
            end
            S_RUN: begin
                if (ss_ev) begin
                    // Pause freezes the count exactly where it is, even on
                    // the wrap cycle, so no tick is lost or duplicated.
                    state_d = S_PAUSE;
                end else if (wrap) begin
                    pcnt_d = '0;
                    tick_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (ss_ev) state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
                pcnt_d  = '0;
            end
        endcase

        // Clear overrides everything, including a coincident start/stop.
        if (clr_ev) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            tick_d  = 1'b0;
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            tick_q     <= 1'b0;
            clr_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            tick_q     <= tick_d;
            clr_q      <= clr_d;
            running_q  <= running_d;
        end
    end

    assign tick    = tick_q;
    assign clr     = clr_q;
    assign running = running_q;

endmodule

// File: tb/tb_sec_tick_ctrl.sv
// Bench for sec_tick_ctrl with TICK_DIV=4, DEB_CYC=3. A per-cycle vector
// table holds inputs and the expected registered outputs after the next
// rising edge; expectations go through a queue between drive and check.
module tb_sec_tick_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB_CYC  = 3;

    logic clk = 1'b0;
    logic rst_n, btn_ss, btn_clr;
    logic tick, clr, running;

    sec_tick_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
        .tick    (tick),
        .clr     (clr),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic ss;
        logic cl;
        logic e_tick;
        logic e_clr;
        logic e_run;
    } vec_t;

    typedef struct {
        int   idx;
        logic t;
        logic c;
        logic r;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    task automatic add(input logic r, input logic s, input logic c,
                       input logic et, input logic ec, input logic er, input int n);
        vec_t v;
        v.rst_n = r; v.ss = s; v.cl = c;
        v.e_tick = et; v.e_clr = ec; v.e_run = er;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at vector %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    // tick and clr must never coincide
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (tick === 1'b1 && clr === 1'b1) begin
                errors++;
                $display("FAIL tick_clr_overlap at t=%0t: tick=%b clr=%b, required not both 1",
                         $time, tick, clr);
            end
        end
    end

    initial begin
        exp_t e;
        //   rst ss clr  tick clr run  count
        // reset
        add(0, 0, 0,  0, 0, 0, 2);     // 0-1
        // clean start press: running 6 edges later, ticks every 4 after that
        add(1, 1, 0,  0, 0, 0, 5);     // 2-6
        add(1, 1, 0,  0, 0, 1, 2);     // 7-8
        add(1, 0, 0,  0, 0, 1, 2);     // 9-10
        add(1, 0, 0,  1, 0, 1, 1);     // 11
        add(1, 0, 0,  0, 0, 1, 3);     // 12-14
        add(1, 0, 0,  1, 0, 1, 1);     // 15
        // second press lands while the prescaler reads 1 -> pause
        add(1, 1, 0,  0, 0, 1, 3);     // 16-18
        add(1, 1, 0,  1, 0, 1, 1);     // 19
        add(1, 0, 0,  0, 0, 1, 1);     // 20
        add(1, 0, 0,  0, 0, 0, 7);     // 21-27 paused, no ticks
        // third press resumes; first tick after the 3 remaining RUN cycles
        add(1, 1, 0,  0, 0, 0, 4);     // 28-31
        add(1, 0, 0,  0, 0, 0, 1);     // 32
        add(1, 0, 0,  0, 0, 1, 3);     // 33-35
        add(1, 0, 0,  1, 0, 1, 1);     // 36
        add(1, 0, 0,  0, 0, 1, 2);     // 37-38
        // clear press whose event lands on the wrap cycle
        add(1, 0, 1,  0, 0, 1, 1);     // 39
        add(1, 0, 1,  1, 0, 1, 1);     // 40
        add(1, 0, 1,  0, 0, 1, 2);     // 41-42
        add(1, 0, 0,  0, 0, 1, 1);     // 43
        add(1, 0, 0,  0, 1, 0, 1);     // 44 clr wins, tick suppressed
        add(1, 0, 0,  0, 0, 0, 7);     // 45-51 idle, prescaler zeroed
        // clear and start together while idle
        add(1, 1, 1,  0, 0, 0, 4);     // 52-55
        add(1, 0, 0,  0, 0, 0, 1);     // 56
        add(1, 0, 0,  0, 1, 0, 1);     // 57
        add(1, 0, 0,  0, 0, 0, 6);     // 58-63
        // single-cycle bounce never reaches DEB_CYC stable cycles
        add(1, 1, 0,  0, 0, 0, 1);     // 64
        add(1, 0, 0,  0, 0, 0, 1);     // 65
        add(1, 1, 0,  0, 0, 0, 1);     // 66
        add(1, 0, 0,  0, 0, 0, 7);     // 67-73
        // run, then one-cycle reset with start held high
        add(1, 1, 0,  0, 0, 0, 5);     // 74-78
        add(1, 1, 0,  0, 0, 1, 4);     // 79-82
        add(1, 1, 0,  1, 0, 1, 1);     // 83
        add(1, 1, 0,  0, 0, 1, 1);     // 84
        add(0, 1, 0,  0, 0, 0, 1);     // 85
        add(1, 1, 0,  0, 0, 0, 5);     // 86-90
        add(1, 1, 0,  0, 0, 1, 4);     // 91-94
        add(1, 1, 0,  1, 0, 1, 1);     // 95
        add(1, 1, 0,  0, 0, 1, 2);     // 96-97

        rst_n = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
        started = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t p;
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            btn_ss  = vecs[i].ss;
            btn_clr = vecs[i].cl;
            p.idx = i; p.t = vecs[i].e_tick; p.c = vecs[i].e_clr; p.r = vecs[i].e_run;
            sb.push_back(p);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at vector %0d: got 0 entries, expected 1", i);
            end else begin
                e = sb.pop_front();
                chk("tick",    e.idx, tick,    e.t);
                chk("clr",     e.idx, clr,     e.c);
                chk("running", e.idx, running, e.r);
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the main sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion by %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
